// File: rtl/rob_rename_buffer.sv
// Per-ROB-entry result/readiness store read by rename to resolve ROB-tagged operands.
// Optional macro ROB_RENAME_BYPASS_EN forwards a same-cycle CDB result to the read ports.
module rob_rename_buffer #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2
) (
  input  logic           clk,
  input  logic           globalResetN,
  input  logic           validBroadcast,
  input  logic [ROB:0]   robEntry,
  input  logic [WIDTH:0] result,
  input  logic           robWrite,
  input  logic           freeze,
  input  logic [ROB:0]   robAllocation,
  input  logic           wcommit,
  input  logic [ROB:0]   ROBcommit,
  input  logic [ROB:0]   rob1,
  input  logic [ROB:0]   rob2,
  output logic [WIDTH:0] ROBValue1,
  output logic [WIDTH:0] ROBValue2,
  output logic           valid1,
  output logic           valid2
);

  localparam int DEPTH = 1 << (ROB + 1);

  logic [WIDTH:0] value_q [DEPTH];
  logic [WIDTH:0] value_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic allocate;

  assign allocate = robWrite && !freeze;

  // Later assignments win: commit-clear, then broadcast, then allocation.
  // An allocation colliding with a broadcast discards the broadcast entirely.
  always_comb begin
    value_d = value_q;
    valid_d = valid_q;
    if (wcommit) begin
      valid_d[ROBcommit] = 1'b0;
    end
    if (validBroadcast && !(allocate && (robAllocation == robEntry))) begin
      value_d[robEntry] = result;
      valid_d[robEntry] = 1'b1;
    end
    if (allocate) begin
      valid_d[robAllocation] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!globalResetN) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        value_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        value_q[i] <= value_d[i];
      end
    end
  end

`ifdef ROB_RENAME_BYPASS_EN
  always_comb begin
    if (validBroadcast && (robEntry == rob1)) begin
      ROBValue1 = result;
      valid1    = 1'b1;
    end else begin
      ROBValue1 = value_q[rob1];
      valid1    = valid_q[rob1];
    end
    if (validBroadcast && (robEntry == rob2)) begin
      ROBValue2 = result;
      valid2    = 1'b1;
    end else begin
      ROBValue2 = value_q[rob2];
      valid2    = valid_q[rob2];
    end
  end
`else
  assign ROBValue1 = value_q[rob1];
  assign valid1    = valid_q[rob1];
  assign ROBValue2 = value_q[rob2];
  assign valid2    = valid_q[rob2];
`endif

endmodule

// File: tb/tb_rob_rename_buffer.sv
// Self-checking bench for rob_rename_buffer: directed plan steps, then random traffic
// against an array-based model of entry values and readiness.
module tb_rob_rename_buffer;

  logic        clk = 1'b0;
  logic        globalResetN;
  logic        validBroadcast;
  logic [2:0]  robEntry;
  logic [31:0] result;
  logic        robWrite;
  logic        freeze;
  logic [2:0]  robAllocation;
  logic        wcommit;
  logic [2:0]  ROBcommit;
  logic [2:0]  rob1;
  logic [2:0]  rob2;
  logic [31:0] ROBValue1;
  logic [31:0] ROBValue2;
  logic        valid1;
  logic        valid2;

  int checks = 0;
  int errors = 0;

  logic [31:0] mVal   [8];
  bit          mValid [8];
  bit          mKnown [8];

  rob_rename_buffer #(.WIDTH(31), .ROB(2)) dut (
    .clk(clk), .globalResetN(globalResetN),
    .validBroadcast(validBroadcast), .robEntry(robEntry), .result(result),
    .robWrite(robWrite), .freeze(freeze), .robAllocation(robAllocation),
    .wcommit(wcommit), .ROBcommit(ROBcommit),
    .rob1(rob1), .rob2(rob2),
    .ROBValue1(ROBValue1), .ROBValue2(ROBValue2),
    .valid1(valid1), .valid2(valid2)
  );

  always #5 clk = ~clk;

  // Model update at the edge; allocation wins over broadcast, broadcast over commit.
  task automatic updateModel();
    bit alloc;
    alloc = robWrite && !freeze;
    if (!globalResetN) begin
      for (int i = 0; i < 8; i++) begin
        mVal[i] = 32'h0; mValid[i] = 1'b0; mKnown[i] = 1'b1;
      end
    end else begin
      if (wcommit) mValid[ROBcommit] = 1'b0;
      if (validBroadcast) begin
        if (alloc && robAllocation == robEntry) begin
          mKnown[robEntry] = 1'b0;
        end else begin
          mVal[robEntry] = result; mValid[robEntry] = 1'b1; mKnown[robEntry] = 1'b1;
        end
      end
      if (alloc) mValid[robAllocation] = 1'b0;
    end
  endtask

  task automatic checkPort(string tag, logic [2:0] r, logic [31:0] gotV, logic gotOk);
    logic [31:0] expV;
    bit expOk;
    bit cmpV;
    expV  = mVal[r];
    expOk = mValid[r];
    cmpV  = mKnown[r];
`ifdef ROB_RENAME_BYPASS_EN
    if (validBroadcast && robEntry == r) begin
      expV = result; expOk = 1'b1; cmpV = 1'b1;
    end
`endif
    checks++;
    assert (gotOk === expOk) else begin
      errors++;
      $error("[TB] FAIL %s valid: got %b expected %b (tag %0d)", tag, gotOk, expOk, r);
    end
    if (cmpV) begin
      checks++;
      assert (gotV === expV) else begin
        errors++;
        $error("[TB] FAIL %s value: got %h expected %h (tag %0d)", tag, gotV, expV, r);
      end
    end
  endtask

  task automatic checkOutput(string tag);
    checkPort({tag, "/p1"}, rob1, ROBValue1, valid1);
    checkPort({tag, "/p2"}, rob2, ROBValue2, valid2);
  endtask

  task automatic checkConst(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic settle(string tag);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic applyStimulus();
    globalResetN   = 1'b1;
    validBroadcast = 1'b0;
    robWrite       = 1'b0;
    freeze         = 1'b0;
    wcommit        = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mVal[i] = 32'h0; mValid[i] = 1'b0; mKnown[i] = 1'b0;
    end
    applyStimulus();
    robEntry = 3'd0; result = 32'h0; robAllocation = 3'd0; ROBcommit = 3'd0;
    rob1 = 3'd3; rob2 = 3'd5;

    globalResetN = 1'b0;
    tick();
    applyStimulus();
    settle("reset");
    checkConst("reset v1", {31'h0, valid1}, 32'h0);
    checkConst("reset v2", {31'h0, valid2}, 32'h0);
    checkConst("reset val1", ROBValue1, 32'h0);
    checkConst("reset val2", ROBValue2, 32'h0);
    tick();

    validBroadcast = 1'b1; robEntry = 3'd2; result = 32'hDEADBEEF; rob1 = 3'd2;
    settle("bcast");
`ifdef ROB_RENAME_BYPASS_EN
    checkConst("bypass val1", ROBValue1, 32'hDEADBEEF);
`else
    checkConst("no bypass v1", {31'h0, valid1}, 32'h0);
`endif
    tick();
    applyStimulus();
    settle("bcast read");
    checkConst("bcast val1", ROBValue1, 32'hDEADBEEF);
    checkConst("bcast v1", {31'h0, valid1}, 32'h1);
    tick();

    robWrite = 1'b1; freeze = 1'b1; robAllocation = 3'd2;
    settle("frozen alloc");
    tick();
    applyStimulus();
    settle("after frozen");
    checkConst("frozen keeps v1", {31'h0, valid1}, 32'h1);
    tick();

    robWrite = 1'b1; robAllocation = 3'd2;
    settle("alloc");
    tick();
    applyStimulus();
    settle("after alloc");
    checkConst("alloc clears v1", {31'h0, valid1}, 32'h0);
    tick();

    validBroadcast = 1'b1; robEntry = 3'd6; result = 32'h12345678;
    tick();
    applyStimulus();
    wcommit = 1'b1; ROBcommit = 3'd6; rob2 = 3'd6;
    settle("commit");
    tick();
    applyStimulus();
    settle("after commit");
    checkConst("commit clears v2", {31'h0, valid2}, 32'h0);
    checkConst("commit keeps val2", ROBValue2, 32'h12345678);
    tick();

    robWrite = 1'b1; robAllocation = 3'd4;
    validBroadcast = 1'b1; robEntry = 3'd4; result = 32'h55555555;
    tick();
    applyStimulus();
    rob1 = 3'd4;
    settle("alloc+bcast");
    checkConst("alloc beats bcast", {31'h0, valid1}, 32'h0);
    tick();

    validBroadcast = 1'b1; robEntry = 3'd1; result = 32'h00001111;
    wcommit = 1'b1; ROBcommit = 3'd1;
    tick();
    applyStimulus();
    rob1 = 3'd1;
    settle("bcast+commit");
    checkConst("bcast beats commit v", {31'h0, valid1}, 32'h1);
    checkConst("bcast beats commit val", ROBValue1, 32'h00001111);
    tick();

    validBroadcast = 1'b1; robEntry = 3'd7; result = 32'h77777777;
    tick();
    applyStimulus();
    validBroadcast = 1'b1; robEntry = 3'd0; result = 32'h00000022;
    wcommit = 1'b1; ROBcommit = 3'd7;
    tick();
    applyStimulus();
    rob1 = 3'd0; rob2 = 3'd7;
    settle("split entries");
    checkConst("split v0", {31'h0, valid1}, 32'h1);
    checkConst("split v7", {31'h0, valid2}, 32'h0);
    tick();

    validBroadcast = 1'b1; robEntry = 3'd7; result = 32'hA;
    tick();
    validBroadcast = 1'b1; robEntry = 3'd0; result = 32'hB;
    tick();
    applyStimulus();
    rob1 = 3'd7; rob2 = 3'd0;
    settle("wrap tags");
    checkConst("wrap val1", ROBValue1, 32'hA);
    checkConst("wrap val2", ROBValue2, 32'hB);
    checkConst("wrap valid", {30'h0, valid1, valid2}, 32'h3);
    tick();
    rob2 = 3'd7;
    settle("same tag");
    checkConst("same tag val1", ROBValue1, 32'hA);
    checkConst("same tag val2", ROBValue2, 32'hA);
    tick();

    for (int n = 0; n < 400; n++) begin
      globalResetN   = ($urandom_range(63) != 0);
      validBroadcast = $urandom_range(1);
      robEntry       = 3'($urandom_range(7));
      result         = $urandom;
      robWrite       = ($urandom_range(2) == 0);
      freeze         = ($urandom_range(3) == 0);
      robAllocation  = 3'($urandom_range(7));
      wcommit        = ($urandom_range(2) == 0);
      ROBcommit      = 3'($urandom_range(7));
      rob1           = 3'($urandom_range(7));
      rob2           = ($urandom_range(4) == 0) ? rob1 : 3'($urandom_range(7));
      settle("random");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
